player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
- Game-state and player-motion controller for the dino game.
- Sits between the debounced buttons and the rendering and score blocks, downstream of the 20 Hz tick generator and the collision detector in graphics.
- Runs the IDLE/RUNNING/GAME_OVER state machine and integrates jump physics at 20 Hz.
- Drives the dino height to the dino renderer and the start/over/jump pulses to the score and audio blocks.

Parameters:
JUMP_VEL, 10, initial upward velocity loaded on jump (height units per tick)
GRAVITY, 1, velocity decrement per physics tick
FAST_FALL, 3, velocity decrement per physics tick while button_down is held mid-air
MAX_POS, 63, ceiling clamp for player_position

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
game_tick  in  2  [0] decision strobe; [1] physics strobe, asserted exactly one clk after [0]; each is a 1-clk pulse
button_up  in  1  debounced jump/start level
button_down  in  1  debounced duck level
crash  in  1  collision level from graphics, valid any clk
player_position  out  6  dino height above ground, 0 = on ground
game_start_pulse  out  1  1-clk pulse on entering RUNNING
game_over_pulse  out  1  1-clk pulse on entering GAME_OVER
jump_pulse  out  1  1-clk pulse when a jump is launched
jumping  out  1  high while airborne
ducking  out  1  high while ducking on ground
game_state  out  2  0=IDLE, 1=RUNNING, 2=GAME_OVER

Behaviour:
- All outputs are registered. On reset, every output is 0 and game_state=IDLE. Internal state on reset: vel=0, the released flag=0, the crash latch=0.
- IDLE:
  - On game_tick[0] with button_up=1: go to RUNNING, game_start_pulse on the next clk.
  - player_position is held at 0.
- RUNNING, decision step (game_tick[0]):
  - If jumping=0 and button_up=1: vel<=JUMP_VEL, jumping<=1, jump_pulse pulses for 1 clk, ducking<=0.
  - Otherwise ducking<=button_down & ~jumping.
  - If both buttons are pressed on the ground, the jump wins.
- RUNNING, physics step (game_tick[1]), only while jumping=1:
  - next = pos + vel, computed as 8-bit signed.
  - If next<=0: pos<=0, vel<=0, jumping<=0.
  - Else if next>MAX_POS: pos<=MAX_POS.
  - Else pos<=next.
  - vel <= vel - (button_down ? FAST_FALL : GRAVITY). vel is 6-bit signed and saturates at -32.
  - A jump launched at game_tick[0] moves at the immediately following game_tick[1].
- Crash:
  - crash=1 on any clk in RUNNING: go to GAME_OVER on the next clk, game_over_pulse for 1 clk, released<=0.
  - Crash has priority over a jump or physics update in the same clk. The position is frozen at its crash value.
  - jumping is frozen; ducking<=0.
- GAME_OVER:
  - crash is ignored.
  - On game_tick[0]: if button_up=0, set released<=1; if released=1 and button_up=1, restart.
  - Restart: go to RUNNING, game_start_pulse, pos<=0, vel<=0, jumping<=0.
  - Holding the button through the crash must not restart the game.
- A tick arriving outside a valid state has no effect.
- Reset mid-jump returns immediately (asynchronously) to all-zero outputs and IDLE.
- The pulses never overlap except jump_pulse, which may follow game_start_pulse on a later tick.

Decomposition:
- Package player_pkg holds:
  - the state enum: IDLE=2'd0, RUNNING=2'd1, GAME_OVER=2'd2;
  - default constants JUMP_VEL_D, GRAVITY_D, FAST_FALL_D, MAX_POS_D;
  - widths POS_W=6 and VEL_W=6.
- One sub-module, player_physics, holds the pos/vel registers, the saturating integrator and the landing/clamp logic.
- The top level holds the FSM, the released flag and the pulse generation.

Test Plan:
1. Reset, then button_up=1 at tick[0] -> game_state=1, a single game_start_pulse, player_position=0.
2. Jump with defaults and buttons otherwise released -> jump_pulse once; positions on successive tick[1] are 10,19,27,34,40,45,49,52,54,55,55,54,52,49,45,40,34,27,19,10,0; jumping drops to 0 at the final 0.
3. Fast fall: hold button_down from the apex (55) -> vel decrements by 3 per tick, the dino lands earlier, pos never goes negative, jumping=0 on landing.
4. crash pulse mid-jump at pos=34 -> game_over_pulse once, state=2, pos held at 34 through 10 ticks, jumping held.
5. button_up held through the crash -> no restart; release at one tick[0], press at a later tick[0] -> restart with pos=0, game_start_pulse.
6. On ground, both buttons held at tick[0] -> jump wins, ducking=0. Release up, hold down -> ducking=1 at the next tick[0]. Assert rst_n=0 mid-jump -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg
// Shared types and constants for the dino game motion controller.
//   game_state_e : IDLE / RUNNING / GAME_OVER encoding driven on game_state
//   *_D          : default jump physics constants (height units per tick)
//   POS_W/VEL_W  : widths of the height and signed velocity registers
package player_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUNNING   = 2'd1,
    GAME_OVER = 2'd2
  } game_state_e;

  localparam int JUMP_VEL_D  = 10;
  localparam int GRAVITY_D   = 1;
  localparam int FAST_FALL_D = 3;
  localparam int MAX_POS_D   = 63;

  localparam int POS_W = 6;
  localparam int VEL_W = 6;

endpackage

// File: rtl/player_physics.sv
// player_physics
// Height / velocity integrator for the dino jump.
//   clk, rst_n   : clock, asynchronous active-low reset
//   launch_i     : load the jump velocity and mark the dino airborne
//   step_i       : physics strobe; integrates only while airborne
//   fast_i       : use the fast-fall decrement instead of gravity
//   restart_i    : clear position, velocity and airborne flag
//   pos_o        : registered height above ground (0 = on ground)
//   jumping_o    : registered airborne flag
module player_physics
  import player_pkg::*;
#(
  parameter int JUMP_VEL  = JUMP_VEL_D,
  parameter int GRAVITY   = GRAVITY_D,
  parameter int FAST_FALL = FAST_FALL_D,
  parameter int MAX_POS   = MAX_POS_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             launch_i,
  input  logic             step_i,
  input  logic             fast_i,
  input  logic             restart_i,
  output logic [POS_W-1:0] pos_o,
  output logic             jumping_o
);

  // Sums are formed 8 bits wide so pos + vel can go below zero or above
  // the ceiling without wrapping before the landing/clamp decision.
  localparam int SUM_W = 8;

  localparam logic signed [SUM_W-1:0] ZERO_S = '0;
  localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'(MAX_POS);
  localparam logic signed [SUM_W-1:0] GRAV_S = SUM_W'(GRAVITY);
  localparam logic signed [SUM_W-1:0] FAST_S = SUM_W'(FAST_FALL);
  localparam logic signed [SUM_W-1:0] VMIN_S = -SUM_W'(32);
  localparam logic signed [VEL_W-1:0] VMIN_V = {1'b1, {(VEL_W-1){1'b0}}};

  logic [POS_W-1:0]        pos_q, pos_d;
  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic                    jumping_q, jumping_d;

  logic signed [SUM_W-1:0] pos_ext, vel_ext, next_pos, vel_wide;

  always_comb begin
    pos_ext   = {{(SUM_W-POS_W){1'b0}}, pos_q};
    vel_ext   = {{(SUM_W-VEL_W){vel_q[VEL_W-1]}}, vel_q};
    next_pos  = pos_ext + vel_ext;
    vel_wide  = vel_ext - (fast_i ? FAST_S : GRAV_S);

    pos_d     = pos_q;
    vel_d     = vel_q;
    jumping_d = jumping_q;

    if (restart_i) begin
      pos_d     = '0;
      vel_d     = '0;
      jumping_d = 1'b0;
    end else if (launch_i) begin
      vel_d     = VEL_W'(JUMP_VEL);
      jumping_d = 1'b1;
    end else if (step_i && jumping_q) begin
      if (next_pos <= ZERO_S) begin
        // Landing: snap to the ground and stop.
        pos_d     = '0;
        vel_d     = '0;
        jumping_d = 1'b0;
      end else begin
        pos_d = (next_pos > MAX_S) ? POS_W'(MAX_POS) : next_pos[POS_W-1:0];
        // Velocity saturates at the most negative 6-bit value.
        vel_d = (vel_wide < VMIN_S) ? VMIN_V : vel_wide[VEL_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q     <= '0;
      vel_q     <= '0;
      jumping_q <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      jumping_q <= jumping_d;
    end
  end

  assign pos_o     = pos_q;
  assign jumping_o = jumping_q;

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl
// Game-state machine and jump control for the dino game.
//   clk, rst_n        : clock, asynchronous active-low reset
//   game_tick[1:0]    : [0] decision strobe, [1] physics strobe one clk later
//   button_up/down    : debounced jump/start and duck levels
//   crash             : collision level from graphics
//   player_position   : dino height (0 = ground)
//   game_start_pulse  : 1-clk pulse on entering RUNNING
//   game_over_pulse   : 1-clk pulse on entering GAME_OVER
//   jump_pulse        : 1-clk pulse when a jump is launched
//   jumping, ducking  : airborne / ducking-on-ground levels
//   game_state        : current FSM state (doubles as the debug view)
// Handshake: there is none; game_tick bits are single-clk strobes that are
// sampled once, and every output is a register updated on the clk edge.
module player_motion_ctrl
  import player_pkg::*;
#(
  parameter int JUMP_VEL  = JUMP_VEL_D,
  parameter int GRAVITY   = GRAVITY_D,
  parameter int FAST_FALL = FAST_FALL_D,
  parameter int MAX_POS   = MAX_POS_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       game_tick,
  input  logic             button_up,
  input  logic             button_down,
  input  logic             crash,
  output logic [POS_W-1:0] player_position,
  output logic             game_start_pulse,
  output logic             game_over_pulse,
  output logic             jump_pulse,
  output logic             jumping,
  output logic             ducking,
  output logic [1:0]       game_state
);

  game_state_e state_q;
  logic        released_q;
  logic        start_q, over_q, jump_q, duck_q;

  logic running, launch, step, restart;

  // A crash in RUNNING wins over any jump or physics update in that clk,
  // which freezes the position and the airborne flag.
  assign running = (state_q == RUNNING) && !crash;
  assign launch  = running && game_tick[0] && !jumping && button_up;
  assign step    = running && !game_tick[0] && game_tick[1];
  // The released flag guarantees the button was seen low after the crash.
  assign restart = (state_q == GAME_OVER) && game_tick[0] && released_q && button_up;

  player_physics #(
    .JUMP_VEL  (JUMP_VEL),
    .GRAVITY   (GRAVITY),
    .FAST_FALL (FAST_FALL),
    .MAX_POS   (MAX_POS)
  ) u_physics (
    .clk       (clk),
    .rst_n     (rst_n),
    .launch_i  (launch),
    .step_i    (step),
    .fast_i    (button_down),
    .restart_i (restart),
    .pos_o     (player_position),
    .jumping_o (jumping)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      released_q <= 1'b0;
      start_q    <= 1'b0;
      over_q     <= 1'b0;
      jump_q     <= 1'b0;
      duck_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      over_q  <= 1'b0;
      jump_q  <= launch;
      case (state_q)
        IDLE: begin
          if (game_tick[0] && button_up) begin
            state_q <= RUNNING;
            start_q <= 1'b1;
          end
        end
        RUNNING: begin
          if (crash) begin
            state_q    <= GAME_OVER;
            over_q     <= 1'b1;
            released_q <= 1'b0;
            duck_q     <= 1'b0;
          end else if (game_tick[0]) begin
            duck_q <= launch ? 1'b0 : (button_down & ~jumping);
          end
        end
        GAME_OVER: begin
          if (game_tick[0]) begin
            if (!button_up) begin
              released_q <= 1'b1;
            end else if (released_q) begin
              state_q <= RUNNING;
              start_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign game_start_pulse = start_q;
  assign game_over_pulse  = over_q;
  assign jump_pulse       = jump_q;
  assign ducking          = duck_q;
  assign game_state       = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
module tb_player_motion_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] game_tick;
  logic       button_up, button_down, crash;
  logic [5:0] player_position;
  logic       game_start_pulse, game_over_pulse, jump_pulse, jumping, ducking;
  logic [1:0] game_state;

  always #5 clk = ~clk;

  player_motion_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .game_tick        (game_tick),
    .button_up        (button_up),
    .button_down      (button_down),
    .crash            (crash),
    .player_position  (player_position),
    .game_start_pulse (game_start_pulse),
    .game_over_pulse  (game_over_pulse),
    .jump_pulse       (jump_pulse),
    .jumping          (jumping),
    .ducking          (ducking),
    .game_state       (game_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // Game rules in plain integers: state 0/1/2, height, signed velocity.
  int m_state, m_pos, m_vel, m_jump, m_duck, m_rel, m_start, m_over, m_jp;

  function automatic void model_reset();
    m_state = 0; m_pos = 0; m_vel = 0; m_jump = 0; m_duck = 0;
    m_rel = 0; m_start = 0; m_over = 0; m_jp = 0;
  endfunction

  function automatic void model_step();
    int nxt;
    m_start = 0; m_over = 0; m_jp = 0;
    if (m_state == 0) begin
      if (game_tick[0] && button_up) begin m_state = 1; m_start = 1; end
    end else if (m_state == 1) begin
      if (crash) begin
        m_state = 2; m_over = 1; m_rel = 0; m_duck = 0;
      end else if (game_tick[0]) begin
        if (m_jump == 0 && button_up) begin
          m_vel = 10; m_jump = 1; m_jp = 1; m_duck = 0;
        end else begin
          m_duck = (button_down && m_jump == 0) ? 1 : 0;
        end
      end else if (game_tick[1] && m_jump == 1) begin
        nxt = m_pos + m_vel;
        if (nxt <= 0) begin
          m_pos = 0; m_vel = 0; m_jump = 0;
        end else begin
          m_pos = (nxt > 63) ? 63 : nxt;
          m_vel = m_vel - (button_down ? 3 : 1);
          if (m_vel < -32) m_vel = -32;
        end
      end
    end else begin
      if (game_tick[0]) begin
        if (!button_up) m_rel = 1;
        else if (m_rel == 1) begin
          m_state = 1; m_start = 1; m_pos = 0; m_vel = 0; m_jump = 0;
        end
      end
    end
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all();
    check("state", game_state, m_state);
    check("pos", player_position, m_pos);
    check("jumping", jumping, m_jump);
    check("ducking", ducking, m_duck);
    check("start_pulse", game_start_pulse, m_start);
    check("over_pulse", game_over_pulse, m_over);
    check("jump_pulse", jump_pulse, m_jp);
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge: apply inputs, advance the model, check next negedge.
  task automatic cyc(input logic [1:0] t, input logic u, input logic d, input logic c);
    game_tick = t; button_up = u; button_down = d; crash = c;
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick_pair(input logic u, input logic d, input int gap);
    cyc(2'b01, u, d, 1'b0);
    cyc(2'b10, u, d, 1'b0);
    for (int g = 0; g < gap; g++) cyc(2'b00, u, d, 1'b0);
  endtask

  int jump_seq[21] = '{10, 19, 27, 34, 40, 45, 49, 52, 54, 55, 55,
                       54, 52, 49, 45, 40, 34, 27, 19, 10, 0};
  int fast_seq[17] = '{10, 19, 27, 34, 40, 45, 49, 52, 54, 55, 55,
                       52, 46, 37, 25, 10, 0};

  initial begin
    rst_n = 1'b0; game_tick = 2'b00; button_up = 1'b0; button_down = 1'b0; crash = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: start the game
    tick_pair(1'b1, 1'b0, 1);
    check("start_state", game_state, 1);
    tick_pair(1'b0, 1'b0, 1);

    // 2: full jump with default gravity
    for (int i = 0; i < 21; i++) begin
      tick_pair(i == 0, 1'b0, 1);
      check("jump_seq", player_position, jump_seq[i]);
      check("jump_air", jumping, (i < 20) ? 1 : 0);
    end

    // 3: fast fall from the apex
    for (int i = 0; i < 17; i++) begin
      tick_pair(i == 0, i >= 10, 1);
      check("fast_seq", player_position, fast_seq[i]);
      check("fast_air", jumping, (i < 16) ? 1 : 0);
    end
    tick_pair(1'b0, 1'b0, 1);

    // 4: crash mid-jump at height 34, frozen through 10 ticks
    for (int i = 0; i < 4; i++) tick_pair(i == 0, 1'b0, 1);
    cyc(2'b00, 1'b0, 1'b0, 1'b1);
    check("crash_state", game_state, 2);
    for (int i = 0; i < 10; i++) begin
      tick_pair(1'b0, 1'b0, 1);
      check("crash_hold_pos", player_position, 34);
      check("crash_hold_air", jumping, 1);
    end
    tick_pair(1'b1, 1'b0, 1);
    check("restart1_pos", player_position, 0);
    check("restart1_state", game_state, 1);
    tick_pair(1'b0, 1'b0, 1);

    // 5: button held through the crash must not restart
    tick_pair(1'b1, 1'b0, 1);
    cyc(2'b00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick_pair(1'b1, 1'b0, 1);
    check("no_restart", game_state, 2);
    tick_pair(1'b0, 1'b0, 1);
    tick_pair(1'b0, 1'b0, 1);
    cyc(2'b01, 1'b1, 1'b0, 1'b0);
    check("restart2_state", game_state, 1);
    check("restart2_pulse", game_start_pulse, 1);
    check("restart2_pos", player_position, 0);
    cyc(2'b10, 1'b0, 1'b0, 1'b0);

    // 6: both buttons on ground -> jump wins; then duck; then async reset
    tick_pair(1'b1, 1'b1, 1);
    check("both_duck", ducking, 0);
    check("both_air", jumping, 1);
    for (int i = 0; i < 22; i++) tick_pair(1'b0, 1'b0, 1);
    tick_pair(1'b0, 1'b1, 1);
    check("duck_ground", ducking, 1);
    tick_pair(1'b1, 1'b0, 1);
    for (int i = 0; i < 3; i++) tick_pair(1'b0, 1'b0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pos", player_position, 0);
    check("arst_state", game_state, 0);
    check("arst_air", jumping, 0);
    check("arst_pulses", {game_start_pulse, game_over_pulse, jump_pulse, ducking}, 0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Random play
    for (int i = 0; i < 250; i++) begin
      logic u, d;
      int gap;
      u   = ($urandom_range(0, 2) == 0);
      d   = ($urandom_range(0, 2) == 0);
      gap = $urandom_range(0, 2);
      cyc(2'b01, u, d, $urandom_range(0, 30) == 0);
      cyc(2'b10, u, d, $urandom_range(0, 30) == 0);
      for (int g = 0; g < gap; g++) cyc(2'b00, u, d, $urandom_range(0, 30) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
